fx_delay: RTL
=============

// Module: fx_delay
// PURPOSE
//  Stereo feedback delay/echo stage (FX 6), directly upstream of the reverb stage (FX 7).
//  - Stores past input frames in a circular buffer and adds delayed copies back in with
//    feedback.
//  - Mixes the dry and delayed signals and passes the result to the reverb.
//  - Processes one stereo frame per sample_en strobe.
// PARAMETERS
//  DATA_W   16  signed two's-complement sample width per channel
//  PARAM_W  7   width of the time/feedback/mix controls (0..127)
//  ADDR_W   10  buffer address width; depth 2^ADDR_W frames; requires ADDR_W >= PARAM_W
// PORTS
//  clk        in   1             system clock
//  reset_n    in   1             asynchronous active-low reset
//  sample_en  in   1             one-cycle strobe: a new frame is present on audio_in
//  audio_in   in   [1:0][DATA_W] stereo input; [0]=L, [1]=R
//  audio_out  out  [1:0][DATA_W] stereo output, registered; feeds the reverb audio_in
//  time       in   PARAM_W       delay length control
//  feedback   in   PARAM_W       echo feedback gain, fb/128
//  mix        in   PARAM_W       wet fraction, mix/128
// BEHAVIOUR
//  - Reset (async, active-low):
//    - audio_out=0; wr_ptr=0; fill count=0; FSM=IDLE.
//    - Buffer RAM contents are not cleared.
//    - Reset mid-frame abandons the frame with no RAM write.
//  - Delay: D = (time+1) << (ADDR_W-PARAM_W). Defaults give 8..1024 frames in steps of 8.
//  - FSM, one frame per pass: IDLE -> RD -> CALC -> WR -> IDLE.
//    - IDLE: on sample_en, latch audio_in, time, feedback and mix; go to RD.
//    - RD: issue a synchronous read at (wr_ptr - D) mod 2^ADDR_W.
//    - CALC: RAM data valid; compute wet, out and write values.
//    - WR: write at wr_ptr; audio_out updates; wr_ptr++ (wraps); fill++ (saturates at 2^ADDR_W).
//  - Latency and timing:
//    - audio_out changes on the 3rd rising edge after the sample_en edge.
//    - audio_out holds its value between frames.
//  - sample_en while FSM != IDLE is ignored. Callers must space strobes >= 4 cycles apart.
//  - Priming: wet=0 while fill < D. This masks stale RAM after reset or after time increases.
//  - Read-before-write: with D = 2^ADDR_W, the read address equals wr_ptr. RD precedes WR,
//    so the oldest frame is read before it is overwritten.
//  - Control changes take effect only at the next latch; there is no mid-frame change.
//  - Arithmetic, per channel, all signed:
//    - out = sat((dry*(128-mix) + wet*mix) >>> 7)
//    - wr  = sat(dry + ((wet*feedback) >>> 7))
//    - Products use a DATA_W+PARAM_W+2 bit width.
//    - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; results never wrap.
//    - Arithmetic shifts floor toward -inf.
//  - L and R are independent and share address, FSM and timing.
// STRUCTURE
//  fx_pkg:
//    - delay_state_t enum {IDLE,RD,CALC,WR}
//    - sat_w() saturation function
//    - MIX_ONE=128 constant
//  Sub-module delay_ram:
//    - simple dual-port RAM, 1 write / 1 read, synchronous read, 1-cycle latency
//    - word = 2*DATA_W ({R,L}); depth 2^ADDR_W; no reset
//  fx_delay holds the FSM, pointers, fill counter, MAC/saturation and output registers.
// TESTING
//  1 Reset: assert reset_n=0 mid-frame -> audio_out=0 immediately. After release, first
//    frame wet=0: in L=0x1000, mix=64 -> out L=0x0800.
//  2 Impulse: time=0 (D=8), fb=0, mix=64; L=0x4000 at frame 0, zeros after ->
//    out L=0x2000 at frames 0 and 8, 0 elsewhere; R=0 throughout.
//  3 Feedback: as test 2 with fb=64 -> out L=0x2000 at frame 0, 0x2000 at frame 8,
//    0x1000 at frame 16, 0x0800 at frame 24.
//  4 Saturation: L=R=0x7FFF every frame, fb=127, mix=64, D=8 -> buffer writes clamp at
//    0x7FFF; out never negative; with L=R=0x8000 outputs clamp at 0x8000.
//  5 Wrap/max: time=127 (D=1024); impulse 0x4000 at frame 0 -> wet=0 for frames 1..1023;
//    echo at frame 1024 with out L=0x2000; wr_ptr wraps cleanly.
//  6 Strobe spacing: sample_en pulsed in RD and CALC -> ignored; exactly one frame
//    processed and audio_out updates once, 3 cycles after the accepted strobe.

Source files
------------

// File: rtl/fx_delay_pkg.sv
// Shared types and helpers for the stereo feedback delay stage.
package fx_delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CALC,
    WR
  } delay_state_t;

  // Unity gain for the 7-bit mix/feedback controls (value/128).
  localparam int MIX_ONE = 128;

  // Clamp a signed value to the range of a w-bit two's-complement number.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x,
                                               input int unsigned       w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fx_delay_if.sv
// Stereo audio + control bundle between the upstream stage and fx_delay.
// The delay length control is named delay_time because "time" is a keyword.
interface fx_delay_if #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 7
);
  logic                    sample_en;
  logic [1:0][DATA_W-1:0]  audio_in;   // [0]=L, [1]=R
  logic [1:0][DATA_W-1:0]  audio_out;  // [0]=L, [1]=R
  logic [PARAM_W-1:0]      delay_time;
  logic [PARAM_W-1:0]      feedback;
  logic [PARAM_W-1:0]      mix;

  modport master (
    output sample_en, audio_in, delay_time, feedback, mix,
    input  audio_out
  );

  modport slave (
    input  sample_en, audio_in, delay_time, feedback, mix,
    output audio_out
  );
endinterface

// File: rtl/fx_delay_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port
// with one cycle of latency. Contents are never reset.
module fx_delay_ram #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Write and registered read; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fx_delay.sv
// Stereo feedback delay/echo: circular frame buffer, feedback into the
// buffer and dry/wet mixing. One frame per sample_en, output three edges
// after the accepted strobe.
module fx_delay
  import fx_delay_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 7,
  parameter int ADDR_W  = 10   // must be >= PARAM_W
) (
  input logic       clk,
  input logic       reset_n,
  fx_delay_if.slave bus
);

  localparam int PW    = DATA_W + PARAM_W + 2;
  localparam int SH    = ADDR_W - PARAM_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [1:0][DATA_W-1:0] frame_t;

  delay_state_t       state_q;
  frame_t             dry_q;
  frame_t             out_res_q;
  frame_t             wr_res_q;
  frame_t             audio_out_q;
  frame_t             out_res_d;
  frame_t             wr_res_d;
  frame_t             rd_frame;
  logic [PARAM_W-1:0] time_q;
  logic [PARAM_W-1:0] fb_q;
  logic [PARAM_W-1:0] mix_q;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W:0]    fill_q;
  logic [ADDR_W:0]    dly;
  logic               primed;
  logic [2*DATA_W-1:0] rd_data;

  logic signed [PW-1:0] dry_x   [2];
  logic signed [PW-1:0] wet_x   [2];
  logic signed [PW-1:0] acc_out [2];
  logic signed [PW-1:0] acc_wr  [2];
  logic signed [31:0]   sat_out [2];
  logic signed [31:0]   sat_wr  [2];
  logic signed [PW-1:0] mixw;
  logic signed [PW-1:0] fbw;

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  // Delay in frames from the latched control; D = 2^ADDR_W makes rd_addr
  // equal wr_ptr, which is safe because RD always precedes WR.
  assign dly     = ((ADDR_W + 1)'(time_q) + (ADDR_W + 1)'(1)) << SH;
  assign rd_addr = wr_ptr_q - dly[ADDR_W-1:0];
  assign primed  = (fill_q >= dly);
  assign rd_frame = rd_data;

  fx_delay_ram #(
    .WORD_W (2 * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (state_q == WR),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_res_q),
    .re_i    (state_q == RD),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Per-channel MAC and saturation for the output and the buffer write-back.
  always_comb begin
    out_res_d = '0;
    wr_res_d  = '0;
    mixw      = {{(PW-PARAM_W){1'b0}}, mix_q};
    fbw       = {{(PW-PARAM_W){1'b0}}, fb_q};
    for (int unsigned ch = 0; ch < 2; ch++) begin
      dry_x[ch]   = {{(PW-DATA_W){dry_q[ch][DATA_W-1]}}, dry_q[ch]};
      wet_x[ch]   = primed ? {{(PW-DATA_W){rd_frame[ch][DATA_W-1]}}, rd_frame[ch]} : '0;
      acc_out[ch] = (dry_x[ch] * (PW'(MIX_ONE) - mixw) + wet_x[ch] * mixw) >>> PARAM_W;
      acc_wr[ch]  = dry_x[ch] + ((wet_x[ch] * fbw) >>> PARAM_W);
      sat_out[ch] = sat_w(32'(acc_out[ch]), DATA_W);
      sat_wr[ch]  = sat_w(32'(acc_wr[ch]), DATA_W);
      out_res_d[ch] = sat_out[ch][DATA_W-1:0];
      wr_res_d[ch]  = sat_wr[ch][DATA_W-1:0];
    end
  end

  // Frame FSM: latch, read, compute, write/output; strobes outside IDLE are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dry_q       <= '0;
      time_q      <= '0;
      fb_q        <= '0;
      mix_q       <= '0;
      out_res_q   <= '0;
      wr_res_q    <= '0;
      audio_out_q <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.sample_en) begin
            dry_q   <= bus.audio_in;
            time_q  <= bus.delay_time;
            fb_q    <= bus.feedback;
            mix_q   <= bus.mix;
            state_q <= RD;
          end
        end
        RD: begin
          state_q <= CALC;
        end
        CALC: begin
          out_res_q <= out_res_d;
          wr_res_q  <= wr_res_d;
          state_q   <= WR;
        end
        WR: begin
          audio_out_q <= out_res_q;
          wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
          if (fill_q != FULL) fill_q <= fill_q + (ADDR_W + 1)'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.audio_out = audio_out_q;

endmodule
